// File: rtl/mc14500b_pkg.sv
// Shared types and constants for the mc14500b ICU and its program sequencer.
package mc14500b_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_t;

  localparam logic [3:0] OPC_NOP0 = 4'h0;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_RTN  = 4'hD;
  localparam logic [3:0] OPC_NOPF = 4'hF;

  localparam int PC_W_DEF        = 7;
  localparam int OP_W_DEF        = 8;
  localparam int STACK_DEPTH_DEF = 4;

  // True for the opcodes whose ICU flag can redirect or stop the sequencer.
  function automatic logic is_flow_op(input logic [3:0] op);
    return (op == OPC_JMP) || (op == OPC_RTN) || (op == OPC_NOPF);
  endfunction

endpackage

// File: rtl/mc14500b_ret_stack.sv
// Return-address LIFO for the mc14500b sequencer call feature.
// Overflowing pushes and underflowing pops are ignored here; the caller flags them.
module mc14500b_ret_stack
  import mc14500b_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int W     = PC_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IDX_W'(sp);
  assign rd_idx  = IDX_W'(sp - SP_W'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  assign pop_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage needs no reset: entries are only read below the stack pointer.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/mc14500b_sequencer.sv
// Program sequencer for the mc14500b ICU: PC, ROM addressing, JMP/RTN/FLGF handling.
// Optional return stack is built when MC14500B_CALL_STACK_EN is defined.
module mc14500b_sequencer
  import mc14500b_pkg::*;
#(
  parameter int          PC_W         = PC_W_DEF,
  parameter int          OP_W         = OP_W_DEF,
  parameter int unsigned RESET_VEC    = 0,
  parameter bit          HALT_ON_FLGF = 1'b1,
  parameter int          STACK_DEPTH  = STACK_DEPTH_DEF
) (
  input  logic            X2,
  input  logic            RST_N,
  input  logic            start,
  input  logic            halt_req,
  output logic [PC_W-1:0] prog_addr,
  input  logic [OP_W+3:0] prog_data,
  output logic [3:0]      INSTR,
  output logic [OP_W-1:0] IO_ADDR,
  input  logic            JMP,
  input  logic            RTN,
  input  logic            FLGF,
  output logic            running,
  output logic            halted,
  output logic            stack_err
);

  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [OP_W-1:0] operand;
  logic            halt_hit;
  logic            unused_sig;

  assign operand  = prog_data[OP_W-1:0];
  assign pc_inc   = pc_q + PC_W'(1);
  assign halt_hit = halt_req || (FLGF && HALT_ON_FLGF);

`ifdef MC14500B_CALL_STACK_EN
  logic            stk_push;
  logic            stk_pop;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;
  logic            err_set;
  logic            err_q;

  mc14500b_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk       (X2),
    .rst_n     (RST_N),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge X2 or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign stack_err  = err_q;
  assign unused_sig = ^operand;
`else
  assign stack_err  = 1'b0;
  assign unused_sig = ^{RTN, operand, 32'(STACK_DEPTH)};
`endif

  always_ff @(posedge X2 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEQ_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef MC14500B_CALL_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_RUN;
          pc_d    = RESET_PC;
        end
      end
      SEQ_RUN: begin
        // The PC always advances in the halting cycle so resume picks up the next instruction.
        if (JMP) begin
          pc_d = operand[PC_W-1:0];
`ifdef MC14500B_CALL_STACK_EN
          if (operand[OP_W-1]) begin
            if (stk_full) err_set  = 1'b1;
            else          stk_push = 1'b1;
          end
`endif
        end
`ifdef MC14500B_CALL_STACK_EN
        else if (RTN) begin
          if (stk_empty) begin
            pc_d    = pc_inc;
            err_set = 1'b1;
          end else begin
            pc_d    = stk_top;
            stk_pop = 1'b1;
          end
        end
`endif
        else begin
          pc_d = pc_inc;
        end
        if (halt_hit) state_d = SEQ_HALT;
      end
      SEQ_HALT: begin
        if (start && !halt_req) state_d = SEQ_RUN;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  assign running   = (state_q == SEQ_RUN);
  assign halted    = (state_q == SEQ_HALT);
  assign prog_addr = pc_q;
  assign INSTR     = running ? prog_data[OP_W+3:OP_W] : OPC_NOP0;
  assign IO_ADDR   = running ? operand : '0;

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Directed bench for mc14500b_sequencer: behavioural ROM, ICU flags decoded from INSTR.
module tb_mc14500b_sequencer;

  logic        X2 = 1'b0;
  logic        RST_N;
  logic        start;
  logic        halt_req;
  logic [6:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  INSTR;
  logic [7:0]  IO_ADDR;
  logic        JMP;
  logic        RTN;
  logic        FLGF;
  logic        running;
  logic        halted;
  logic        stack_err;

  logic [11:0] rom [128];
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef MC14500B_CALL_STACK_EN
  localparam logic STK_EN = 1'b1;
`else
  localparam logic STK_EN = 1'b0;
`endif

  always #5 X2 = ~X2;

  assign prog_data = rom[prog_addr];
  assign JMP  = (INSTR == 4'hC);
  assign RTN  = (INSTR == 4'hD);
  assign FLGF = (INSTR == 4'hF);

  mc14500b_sequencer dut (
    .X2        (X2),
    .RST_N     (RST_N),
    .start     (start),
    .halt_req  (halt_req),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .INSTR     (INSTR),
    .IO_ADDR   (IO_ADDR),
    .JMP       (JMP),
    .RTN       (RTN),
    .FLGF      (FLGF),
    .running   (running),
    .halted    (halted),
    .stack_err (stack_err)
  );

  function automatic logic [11:0] dflt(input int i);
    return {4'h1, 8'(i * 3 + 17)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge X2);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [6:0] pc);
    logic [11:0] w;
    w = rom[pc];
    check({tag, "_pc"},   32'(prog_addr), 32'(pc));
    check({tag, "_run"},  32'(running),   32'd1);
    check({tag, "_hlt"},  32'(halted),    32'd0);
    check({tag, "_ins"},  32'(INSTR),     32'(w[11:8]));
    check({tag, "_io"},   32'(IO_ADDR),   32'(w[7:0]));
  endtask

  task automatic check_halt(input string tag, input logic [6:0] pc);
    check({tag, "_pc"},  32'(prog_addr), 32'(pc));
    check({tag, "_run"}, 32'(running),   32'd0);
    check({tag, "_hlt"}, 32'(halted),    32'd1);
    check({tag, "_ins"}, 32'(INSTR),     32'd0);
    check({tag, "_io"},  32'(IO_ADDR),   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = dflt(i);
    RST_N    = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    repeat (2) tick();
    check("rst_pc",  32'(prog_addr), 32'd0);
    check("rst_run", 32'(running),   32'd0);
    check("rst_hlt", 32'(halted),    32'd0);
    check("rst_ins", 32'(INSTR),     32'd0);
    check("rst_io",  32'(IO_ADDR),   32'd0);
    check("rst_err", 32'(stack_err), 32'd0);

    RST_N    = 1'b1;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("idle_hreq_run", 32'(running), 32'd0);
    check("idle_hreq_hlt", 32'(halted),  32'd0);

    pulse_start();
    check_run("start0", 7'h00);
    for (int p = 1; p <= 5; p++) begin
      tick();
      check_run("seq", 7'(p));
    end

    // Asynchronous reset mid-RUN at PC=5
    RST_N = 1'b0;
    #1;
    check("arst_pc",  32'(prog_addr), 32'd0);
    check("arst_ins", 32'(INSTR),     32'd0);
    check("arst_run", 32'(running),   32'd0);
    tick();
    RST_N = 1'b1;
    pulse_start();
    check_run("restart0", 7'h00);
    tick();
    check_run("restart1", 7'h01);
    tick();
    check_run("restart2", 7'h02);

    // JMP without bubble, then JMP together with halt_req
    rom[7'h03] = {4'hC, 8'h20};
    rom[7'h22] = {4'hC, 8'h20};
    tick();
    check_run("jmp_at3", 7'h03);
    tick();
    check_run("jmp_tgt", 7'h20);
    tick();
    check_run("after_jmp", 7'h21);
    tick();
    check_run("jmp2", 7'h22);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_halt("jmp_halt", 7'h20);
    halt_req = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    check_halt("hreq_wins", 7'h20);
    pulse_start();
    check_run("resume20", 7'h20);

    // FLGF halt at PC=10
    rom[7'h22] = {4'hC, 8'h0A};
    rom[7'h0A] = {4'hF, 8'h5A};
    tick();
    check_run("r21", 7'h21);
    tick();
    check_run("r22", 7'h22);
    tick();
    check_run("flgf_pc", 7'h0A);
    tick();
    check_halt("flgf_halt", 7'h0B);
    pulse_start();
    check_run("flgf_resume", 7'h0B);

    // Sequential wrap from 7E
    rom[7'h0C] = {4'hC, 8'h7E};
    tick();
    check_run("w0c", 7'h0C);
    tick();
    check_run("w7e", 7'h7E);
    tick();
    check_run("w7f", 7'h7F);
    tick();
    check_run("w00", 7'h00);
    tick();
    check_run("w01", 7'h01);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_halt("hreq_halt", 7'h02);

    // RTN with an empty stack at PC=9
    rom[7'h03] = dflt(3);
    rom[7'h09] = {4'hD, 8'h99};
    pulse_start();
    check_run("rs2", 7'h02);
    for (int p = 3; p <= 9; p++) begin
      tick();
      check_run("rs", 7'(p));
    end
    tick();
    check("rtn_empty_pc",  32'(prog_addr), 32'h0A);
    check("rtn_empty_err", 32'(stack_err), 32'(STK_EN));
    tick();
    check_halt("rtn_flgf", 7'h0B);

    // Call with link bit, then RTN
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("err_clr", 32'(stack_err), 32'd0);
    rom[7'h09] = dflt(9);
    rom[7'h04] = {4'hC, 8'hB0};
    rom[7'h30] = {4'hD, 8'h00};
`ifdef MC14500B_CALL_STACK_EN
    rom[7'h05] = {4'hC, 8'h40};
    for (int k = 0; k < 5; k++) rom[7'h40 + k] = {4'hC, 8'h80 | 8'(8'h41 + k)};
    rom[7'h45] = {4'hD, 8'h00};
`endif
    pulse_start();
    check_run("c0", 7'h00);
    for (int p = 1; p <= 4; p++) begin
      tick();
      check_run("c", 7'(p));
    end
    tick();
    check_run("call_tgt", 7'h30);
    tick();
    check_run("call_ret", STK_EN ? 7'h05 : 7'h31);
    check("call_err", 32'(stack_err), 32'd0);

`ifdef MC14500B_CALL_STACK_EN
    tick();
    check_run("nest40", 7'h40);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_run("nest", 7'(7'h40 + k));
    end
    check("nest_err0", 32'(stack_err), 32'd0);
    tick();
    check_run("ovf_tgt", 7'h45);
    check("ovf_err", 32'(stack_err), 32'd1);
    tick();
    check_run("ovf_ret", 7'h44);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc14500b_sequencer.md
Name: mc14500b_sequencer

Overview:
- Program sequencer for the mc14500b ICU.
- Owns the program counter and addresses an asynchronous-read program ROM, then presents the instruction nibble and I/O address to the ICU and the I/O map.
- Acts on the ICU's JMP, RTN and FLGF flags to redirect, return or halt.
- Provides an IDLE/RUN/HALT control state machine for the host.

Parameters:
- PC_W, 7, program counter / ROM address width.
- OP_W, 8, operand field width. Bit OP_W-1 is the link bit; bits PC_W-1:0 are the jump target.
- RESET_VEC, 0, PC value loaded on start from IDLE.
- HALT_ON_FLGF, 1, when 1 a FLGF pulse in RUN halts the sequencer.
- STACK_DEPTH, 4, return-stack depth. Used only with the call-stack feature.

Ports:
- X2  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  IDLE/HALT -> RUN request, single-cycle pulse.
- halt_req  in  1  RUN -> HALT request.
- prog_addr  out  PC_W  ROM address, equal to PC.
- prog_data  in  4+OP_W  ROM word; [OP_W+3:OP_W] = instruction, [OP_W-1:0] = operand.
- INSTR  out  4  instruction nibble to the ICU.
- IO_ADDR  out  OP_W  operand to the I/O decoder.
- JMP  in  1  ICU jump flag.
- RTN  in  1  ICU return flag.
- FLGF  in  1  ICU NOPF flag.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- stack_err  out  1  sticky return-stack overflow/underflow.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, PC=RESET_VEC, stack pointer=0, stack_err=0, running=0, halted=0.
- Clock and reset: single clock X2, all state on its rising edge. Reset assertion is asynchronous, release is synchronous to X2.
- INSTR/IO_ADDR are combinational:
  - RUN: INSTR = prog_data[OP_W+3:OP_W], IO_ADDR = prog_data[OP_W-1:0].
  - IDLE/HALT: INSTR forced to 4'h0 (NOP0), IO_ADDR forced to 0.
- prog_addr = PC at all times.
- ROM read: asynchronous, so prog_data is valid in the same cycle as prog_addr.
- Flag timing: JMP/RTN/FLGF belong to the instruction currently on INSTR and are sampled on that same rising edge. Flags arriving in IDLE/HALT are ignored.
- IDLE:
  - start -> RUN, PC=RESET_VEC.
  - halt_req is ignored.
- RUN, PC next-value priority:
  1. JMP: PC = operand[PC_W-1:0].
  2. RTN (stack feature only): PC = popped address.
  3. Otherwise: PC = PC+1, wrapping modulo 2^PC_W; 2^PC_W-1 -> 0.
- RUN -> HALT when either condition holds:
  - halt_req = 1;
  - FLGF = 1 and HALT_ON_FLGF = 1.
  - The PC update of that same cycle still happens, so resume continues at the next instruction. A JMP in the cycle halt_req is seen still loads its target.
- HALT:
  - start -> RUN with PC unchanged.
  - halt_req held high in HALT keeps HALT; start and halt_req together in HALT: halt_req wins.
  - No path back to IDLE except reset.
- Execution rate: one instruction per X2 cycle in RUN, with no bubble after a JMP.
- RTN skip: the ICU's skip of the instruction after RTN is the ICU's job. The sequencer always fetches sequentially after RTN.
- running/halted are registered state decodes and are never high together.
- Reset mid-RUN: the PC and stack are discarded immediately and INSTR reverts to NOP0.

Optional Feature:
- Macro: MC14500B_CALL_STACK_EN.
- Defined:
  - JMP with operand[OP_W-1]=1 pushes PC+1 (wrapped) onto a STACK_DEPTH-entry LIFO and jumps.
  - RTN pops the LIFO into PC.
  - Push when full: the push is dropped, the jump is still taken, stack_err is set.
  - Pop when empty: PC=PC+1, stack_err is set.
  - JMP and RTN in the same cycle: JMP wins, no pop.
  - stack_err clears only on reset.
  - The ICU skips the instruction at the return address, so programs place a NOP after each call.
- Undefined: the link bit is ignored, the RTN input is unused, there is no stack storage, and stack_err is tied 0.

Decomposition:
- Package mc14500b_pkg (shared with the ICU):
  - seq_state_t enum {SEQ_IDLE, SEQ_RUN, SEQ_HALT};
  - instruction opcode localparams (NOP0=4'h0, NOPF=4'hF, JMP=4'hC, RTN=4'hD);
  - default widths.
- One natural sub-module: mc14500b_ret_stack (LIFO with push/pop/full/empty), instantiated only under the macro.

Test Plan:
- Reset with RST_N=0 mid-RUN at PC=5 -> immediately prog_addr=0, INSTR=0, running=0; after release and start, PC steps 0,1,2 on successive edges.
- Sequential wrap: run from PC=7'h7E -> prog_addr 7E, 7F, 00, 01; IO_ADDR tracks each ROM operand.
- JMP at PC=3 with operand 8'h20 -> next prog_addr=20, no bubble; JMP with halt_req in the same cycle -> halted=1 and PC=20, start resumes at 20.
- FLGF at PC=10 with HALT_ON_FLGF=1 -> halted=1, INSTR=0, PC=11; start -> running=1 at PC 11.
- With MC14500B_CALL_STACK_EN: call from PC=4 with operand 8'hB0 -> PC=30; RTN at 30 -> PC=5; five nested calls with depth 4 -> stack_err=1, fifth jump still taken.
- With MC14500B_CALL_STACK_EN: RTN with empty stack at PC=9 -> PC=10, stack_err=1. Without the macro, the same RTN -> PC=10, stack_err=0.
